// File: rtl/ifft_playback.sv
// Ping-pong playback buffer: takes whole IFFT frames as bursts and replays them one word per
// pacing strobe, flagging dropped frames, malformed frames and starved strobes.
module ifft_playback #(
    parameter int FFT_POINT = 1024,
    parameter int DATA_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_IFFT_valid,
    input  logic signed [DATA_W-1:0] i_IFFT_data,
    input  logic                     i_IFFT_last,
    input  logic                     i_sample_valid,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_overflow,
    output logic                     o_underflow,
    output logic                     o_frame_err
);
    localparam int               CNT_W   = $clog2(FFT_POINT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FFT_POINT - 1);

    localparam logic [0:0] W_FILL = 1'b0;
    localparam logic [0:0] W_DROP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_PLAY = 1'b1;

    // Both banks share one array; the bank index is the address MSB.
    logic signed [DATA_W-1:0] r_mem [0:2*FFT_POINT-1];

    logic [1:0]       r_full;
    logic [0:0]       r_wr_state;
    logic [CNT_W-1:0] r_wr_cnt;
    logic             r_wr_bank;
    logic [0:0]       r_rd_state;
    logic [CNT_W-1:0] r_rd_cnt;
    logic             r_rd_bank;
    logic             r_primed;

    logic                     r_vld_p1;
    logic signed [DATA_W-1:0] r_data_p1;
    logic                     r_overflow_p1;
    logic                     r_underflow_p1;
    logic                     r_frame_err_p1;

    logic       w_drop;
    logic       w_at_end;
    logic       w_done;
    logic       w_len_err;
    logic       w_wr_en;
    logic       w_rd_en;
    logic       w_rd_wrap;
    logic       w_underflow;
    logic [1:0] w_full_set;
    logic [1:0] w_full_clr;

    // Stage p0: write-side decode. A frame is dropped if its first word finds the target bank still full.
    always_comb begin
        w_drop     = (r_wr_state == W_DROP) || ((r_wr_cnt == '0) && r_full[r_wr_bank]);
        w_at_end   = (r_wr_cnt == CNT_MAX);
        w_done     = i_IFFT_valid && i_IFFT_last && w_at_end;
        w_len_err  = i_IFFT_valid && (i_IFFT_last != w_at_end);
        w_wr_en    = i_IFFT_valid && !w_drop;
        w_full_set = '0;
        if (w_done && !w_drop) begin
            w_full_set[r_wr_bank] = 1'b1;
        end
    end

    // Stage p0: read-side decode. A full read bank is playable even before the FSM leaves R_IDLE,
    // which gives the one-cycle fill-to-play path.
    always_comb begin
        w_rd_en     = i_sample_valid && r_full[r_rd_bank];
        w_rd_wrap   = w_rd_en && (r_rd_cnt == CNT_MAX);
        w_underflow = i_sample_valid && !r_full[r_rd_bank] && (r_rd_state == R_IDLE) && r_primed;
        w_full_clr  = '0;
        if (w_rd_wrap) begin
            w_full_clr[r_rd_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= i_IFFT_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state     <= W_FILL;
            r_wr_cnt       <= '0;
            r_wr_bank      <= 1'b0;
            r_overflow_p1  <= 1'b0;
            r_frame_err_p1 <= 1'b0;
        end else begin
            r_overflow_p1  <= w_done && w_drop;
            r_frame_err_p1 <= w_len_err;
            if (i_IFFT_valid) begin
                if (w_done || w_len_err) begin
                    r_wr_state <= W_FILL;
                    r_wr_cnt   <= '0;
                    if (w_done && !w_drop) begin
                        r_wr_bank <= ~r_wr_bank;
                    end
                end else begin
                    r_wr_state <= w_drop ? W_DROP : W_FILL;
                    r_wr_cnt   <= r_wr_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Write and read sides never address the same bank's flag in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= '0;
        end else begin
            r_full <= (r_full | w_full_set) & ~w_full_clr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state     <= R_IDLE;
            r_rd_cnt       <= '0;
            r_rd_bank      <= 1'b0;
            r_primed       <= 1'b0;
            r_underflow_p1 <= 1'b0;
        end else begin
            r_underflow_p1 <= w_underflow;
            if ((r_rd_state == R_IDLE) && r_full[r_rd_bank]) begin
                r_rd_state <= R_PLAY;
                r_primed   <= 1'b1;
            end
            if (w_rd_en) begin
                if (w_rd_wrap) begin
                    r_rd_cnt   <= '0;
                    r_rd_bank  <= ~r_rd_bank;
                    r_rd_state <= (r_full[~r_rd_bank] || w_full_set[~r_rd_bank]) ? R_PLAY : R_IDLE;
                end else begin
                    r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Stage p1: registered RAM read; o_data holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end else begin
            r_vld_p1 <= w_rd_en;
            if (w_rd_en) begin
                r_data_p1 <= r_mem[{r_rd_bank, r_rd_cnt}];
            end
        end
    end

    assign o_valid     = r_vld_p1;
    assign o_data      = r_data_p1;
    assign o_overflow  = r_overflow_p1;
    assign o_underflow = r_underflow_p1;
    assign o_frame_err = r_frame_err_p1;

endmodule

// File: tb/tb_ifft_playback.sv
// Scoreboard bench for ifft_playback: a frame-queue reference model predicts every output word
// and status pulse with its cycle; a negedge monitor pops and compares.
module tb_ifft_playback;
    localparam int N  = 16;
    localparam int DW = 16;
    typedef logic [N*DW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_IFFT_valid = 1'b0;
    logic [DW-1:0] i_IFFT_data = '0;
    logic          i_IFFT_last = 1'b0;
    logic          i_sample_valid = 1'b0;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_overflow;
    logic          o_underflow;
    logic          o_frame_err;

    ifft_playback #(.FFT_POINT(N), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_IFFT_valid   (i_IFFT_valid),
        .i_IFFT_data    (i_IFFT_data),
        .i_IFFT_last    (i_IFFT_last),
        .i_sample_valid (i_sample_valid),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .o_overflow     (o_overflow),
        .o_underflow    (o_underflow),
        .o_frame_err    (o_frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_vld = 0, n_of = 0, n_uf = 0, n_fe = 0;
    int run = 0, max_run = 0;
    logic prev_vld = 1'b0;

    // Reference model state: stored complete frames in arrival order, plus the frame being received.
    frame_t fq[$];
    frame_t part = '0;
    frame_t cur = '0;
    int pos = 0, wcnt = 0;
    bit dropping = 0, primed = 0, do_pop = 0, do_push = 0;

    logic [DW-1:0] exp_data[$];
    int exp_dcyc[$], exp_of[$], exp_uf[$], exp_fe[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    task automatic miss(input string nm, input longint act, input longint exp);
        n_chk++;
        n_err++;
        $display("FAIL %s: got %0d, expected %0d, cycle %0d", nm, act, exp, cyc);
    endtask

    // Model: each clock edge consumes the strobe and the input word against the pre-edge state.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            fq.delete();
            exp_data.delete(); exp_dcyc.delete();
            exp_of.delete(); exp_uf.delete(); exp_fe.delete();
            pos = 0; wcnt = 0; dropping = 0; primed = 0;
        end else begin
            cyc++;
            do_pop = 0;
            do_push = 0;
            if (i_sample_valid) begin
                if (fq.size() > 0) begin
                    cur = fq[0];
                    exp_data.push_back(cur[pos*DW +: DW]);
                    exp_dcyc.push_back(cyc);
                    if (pos == N-1) do_pop = 1;
                    pos++;
                end else if (primed) begin
                    exp_uf.push_back(cyc);
                end
            end
            if (i_IFFT_valid) begin
                if (wcnt == 0) dropping = (fq.size() == 2);
                if (!dropping) part[wcnt*DW +: DW] = i_IFFT_data;
                if (i_IFFT_last && wcnt == N-1) begin
                    if (dropping) exp_of.push_back(cyc);
                    else do_push = 1;
                    wcnt = 0; dropping = 0;
                end else if (i_IFFT_last || wcnt == N-1) begin
                    exp_fe.push_back(cyc);
                    wcnt = 0; dropping = 0;
                end else begin
                    wcnt++;
                end
            end
            if (do_pop) begin
                void'(fq.pop_front());
                pos = 0;
            end
            if (do_push) begin
                fq.push_back(part);
                primed = 1;
            end
        end
    end

    // Monitor: compares what the DUT presents against the head of each expectation queue.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_vld = 1'b0;
            run = 0;
        end else begin
            if (o_valid) begin
                n_vld++;
                run = prev_vld ? run + 1 : 1;
                if (run > max_run) max_run = run;
                if (exp_data.size() == 0) begin
                    miss("valid_unexpected", 1, 0);
                end else begin
                    chk("data", longint'(o_data), longint'(exp_data.pop_front()));
                    chk("valid_cycle", longint'(cyc), longint'(exp_dcyc.pop_front()));
                end
            end else if (exp_dcyc.size() > 0 && exp_dcyc[0] <= cyc) begin
                miss("valid_missing", 0, 1);
                void'(exp_dcyc.pop_front());
                void'(exp_data.pop_front());
            end
            prev_vld = o_valid;

            if (o_overflow) begin
                n_of++;
                if (exp_of.size() == 0) miss("overflow_unexpected", 1, 0);
                else chk("overflow_cycle", longint'(cyc), longint'(exp_of.pop_front()));
            end else if (exp_of.size() > 0 && exp_of[0] <= cyc) begin
                miss("overflow_missing", 0, 1);
                void'(exp_of.pop_front());
            end

            if (o_underflow) begin
                n_uf++;
                if (exp_uf.size() == 0) miss("underflow_unexpected", 1, 0);
                else chk("underflow_cycle", longint'(cyc), longint'(exp_uf.pop_front()));
            end else if (exp_uf.size() > 0 && exp_uf[0] <= cyc) begin
                miss("underflow_missing", 0, 1);
                void'(exp_uf.pop_front());
            end

            if (o_frame_err) begin
                n_fe++;
                if (exp_fe.size() == 0) miss("frame_err_unexpected", 1, 0);
                else chk("frame_err_cycle", longint'(cyc), longint'(exp_fe.pop_front()));
            end else if (exp_fe.size() > 0 && exp_fe[0] <= cyc) begin
                miss("frame_err_missing", 0, 1);
                void'(exp_fe.pop_front());
            end
        end
    end

    task automatic send_frame(input int base, input int len, input int last_at, input bit rnd);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            i_IFFT_valid = 1'b1;
            i_IFFT_data  = rnd ? DW'($urandom) : DW'(base + i);
            i_IFFT_last  = (i == last_at);
        end
    endtask

    task automatic wr_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_IFFT_valid = 1'b0;
            i_IFFT_last  = 1'b0;
        end
    endtask

    task automatic strobes(input int n, input int period);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_sample_valid = 1'b1;
            for (int j = 1; j < period; j++) begin
                @(negedge clk);
                i_sample_valid = 1'b0;
            end
        end
        @(negedge clk);
        i_sample_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) begin
            @(negedge clk);
            i_IFFT_valid   = 1'b0;
            i_IFFT_last    = 1'b0;
            i_sample_valid = 1'b0;
        end
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_o_valid"}, longint'(o_valid), 0);
        chk({tag, "_o_data"}, longint'(o_data), 0);
        chk({tag, "_o_overflow"}, longint'(o_overflow), 0);
        chk({tag, "_o_underflow"}, longint'(o_underflow), 0);
        chk({tag, "_o_frame_err"}, longint'(o_frame_err), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    int v0, u0, o0, f0;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Strobes with nothing ever buffered are silent.
        v0 = n_vld; u0 = n_uf;
        strobes(3, 2);
        settle();
        chk("prefirst_valids", longint'(n_vld - v0), 0);
        chk("prefirst_underflows", longint'(n_uf - u0), 0);

        // Single frame 0..15, strobe every 4 cycles.
        v0 = n_vld;
        send_frame(0, N, N-1, 0);
        wr_idle(2);
        strobes(N, 4);
        settle();
        chk("single_valids", longint'(n_vld - v0), N);

        // Continuous: frames 3 and 4 arrive while 1 and 2 play; strobes every cycle.
        v0 = n_vld; u0 = n_uf; o0 = n_of;
        send_frame(32'h100, N, N-1, 0);
        send_frame(32'h200, N, N-1, 0);
        fork
            strobes(4*N, 1);
            begin
                wr_idle(N);
                send_frame(32'h300, N, N-1, 0);
                send_frame(32'h400, N, N-1, 0);
                wr_idle(1);
            end
        join
        max_run = 0;
        settle();
        chk("cont_valids", longint'(n_vld - v0), 4*N);
        chk("cont_underflows", longint'(n_uf - u0), 0);
        chk("cont_overflows", longint'(n_of - o0), 0);

        // Overflow: three back-to-back bursts, third is dropped.
        v0 = n_vld; o0 = n_of; max_run = 0;
        send_frame(32'h500, N, N-1, 0);
        send_frame(32'h600, N, N-1, 0);
        send_frame(32'h700, N, N-1, 0);
        wr_idle(1);
        settle();
        chk("ovf_pulses", longint'(n_of - o0), 1);
        strobes(2*N, 1);
        settle();
        chk("ovf_valids", longint'(n_vld - v0), 2*N);
        chk("ovf_contiguous_run", longint'(max_run), 2*N);

        // Frame errors: early last, then missing last; neither plays.
        v0 = n_vld; f0 = n_fe;
        send_frame(32'h800, 10, 9, 0);
        wr_idle(1);
        strobes(4, 2);
        settle();
        chk("ferr_short_pulses", longint'(n_fe - f0), 1);
        chk("ferr_short_valids", longint'(n_vld - v0), 0);
        send_frame(32'h900, N, N-1, 0);
        wr_idle(1);
        strobes(N, 1);
        settle();
        chk("ferr_recover_valids", longint'(n_vld - v0), N);
        f0 = n_fe; v0 = n_vld;
        send_frame(32'hA00, N, 99, 0);
        wr_idle(1);
        strobes(2, 1);
        settle();
        chk("ferr_nolast_pulses", longint'(n_fe - f0), 1);
        chk("ferr_nolast_valids", longint'(n_vld - v0), 0);

        // Underflow after a frame has been played.
        v0 = n_vld; u0 = n_uf;
        send_frame(32'hB00, N, N-1, 0);
        wr_idle(1);
        strobes(N, 1);
        strobes(3, 2);
        settle();
        chk("uflow_valids", longint'(n_vld - v0), N);
        chk("uflow_pulses", longint'(n_uf - u0), 3);

        // Asynchronous reset during playout of the first of two buffered frames.
        send_frame(32'hC00, N, N-1, 0);
        send_frame(32'hD00, N, N-1, 0);
        wr_idle(1);
        strobes(6, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        settle();
        @(negedge clk);
        rst_n = 1'b1;
        v0 = n_vld; u0 = n_uf;
        strobes(5, 1);
        settle();
        chk("post_reset_valids", longint'(n_vld - v0), 0);
        chk("post_reset_underflows", longint'(n_uf - u0), 0);
        send_frame(32'hE00, N, N-1, 0);
        wr_idle(1);
        strobes(N, 2);
        settle();
        chk("post_reset_replay_valids", longint'(n_vld - v0), N);

        // Randomised traffic: random data, gaps, occasional malformed frames, random strobes.
        fork
            begin
                int sel;
                int gap;
                for (int f = 0; f < 14; f++) begin
                    sel = $urandom_range(0, 7);
                    gap = $urandom_range(0, 20);
                    wr_idle(gap);
                    if (sel == 0) send_frame(0, 10, 9, 1);
                    else if (sel == 1) send_frame(0, N, 99, 1);
                    else send_frame(0, N, N-1, 1);
                end
                wr_idle(1);
            end
            begin
                for (int k = 0; k < 700; k++) begin
                    @(negedge clk);
                    i_sample_valid = ($urandom_range(0, 2) != 0);
                end
                @(negedge clk);
                i_sample_valid = 1'b0;
            end
        join
        strobes(3*N, 1);
        settle();

        chk("pending_data", longint'(exp_data.size()), 0);
        chk("pending_overflow", longint'(exp_of.size()), 0);
        chk("pending_underflow", longint'(exp_uf.size()), 0);
        chk("pending_frame_err", longint'(exp_fe.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ifft_playback.md
# ifft_playback

Ping-pong playback buffer on the IFFT output side of the FFT datapath. It accepts complete IFFT result frames, which arrive as back-to-back bursts, and replays them one sample per pacing strobe, so the reconstructed signal leaves at the ADC/DAC sample rate. It is the read-out counterpart of the sample-gathering buffer that feeds the FFT, and it adds frame-integrity, overflow and underflow reporting.

## Interface
Parameters:
- FFT_POINT, 1024: words per frame; power of two, ≥ 4.
- DATA_W, 16: sample width.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_IFFT_valid  in  1  input word strobe; no backpressure is possible.
- i_IFFT_data  in  DATA_W  IFFT output word.
- i_IFFT_last  in  1  marks the final word of an IFFT frame; qualified by i_IFFT_valid.
- i_sample_valid  in  1  pacing strobe, one per output sample period.
- o_valid  out  1  output word strobe, one-cycle pulse.
- o_data  out  DATA_W  output word; held between pulses.
- o_overflow  out  1  one-cycle pulse: a frame was dropped because no bank was free.
- o_underflow  out  1  one-cycle pulse: a strobe arrived while primed but no data was ready.
- o_frame_err  out  1  one-cycle pulse: frame length did not match FFT_POINT.

## Operation
- Storage: two banks of FFT_POINT × DATA_W, inferred synchronous-read RAM. Per-bank flag full[b].
- The write side sets full[b]. The read side clears it. The two sides never touch the same bank's flag in the same cycle.
- Write FSM, states W_FILL and W_DROP; counter wr_cnt, width clog2(FFT_POINT); bank pointer wr_bank.
  - On an accepted word with wr_cnt==0: if full[wr_bank]==1, enter W_DROP for this frame. Otherwise write the word.
  - W_FILL writes bank[wr_bank][wr_cnt] and increments wr_cnt.
  - At wr_cnt==FFT_POINT-1 with i_IFFT_last=1: set full[wr_bank], toggle wr_bank, set wr_cnt=0.
  - Frame error, part 1: i_IFFT_last=1 with wr_cnt≠FFT_POINT-1.
  - Frame error, part 2: wr_cnt==FFT_POINT-1 with i_IFFT_last=0.
  - On a frame error: discard the partial frame (bank flag unchanged, wr_bank unchanged), set wr_cnt=0, pulse o_frame_err, return to W_FILL.
  - W_DROP counts words without writing. At the frame end (last, or count reaching FFT_POINT-1), return to W_FILL with wr_cnt=0 and pulse o_overflow. A length error inside W_DROP pulses o_frame_err only.
- Read FSM, states R_IDLE and R_PLAY; counter rd_cnt; pointer rd_bank; flag primed.
  - R_IDLE → R_PLAY when full[rd_bank]==1. Set primed=1 on that transition.
  - In R_PLAY, each i_sample_valid reads bank[rd_bank][rd_cnt] and increments rd_cnt.
  - On the strobe with rd_cnt==FFT_POINT-1: clear full[rd_bank], toggle rd_bank, set rd_cnt=0. Then stay in R_PLAY if the other bank is full, else go to R_IDLE.
  - In R_IDLE with primed=1, i_sample_valid pulses o_underflow. No o_valid is produced.
  - Strobes before the first frame are ignored silently.
- Frames play out in arrival order. Frames are never partially played.

## Timing
- Reset values: every output is 0, full[1:0]=0, wr_bank=rd_bank=0, counters=0, primed=0, both FSMs in their first state (W_FILL, R_IDLE).
- Read latency: an i_sample_valid accepted in R_PLAY at cycle t gives o_valid=1 and the matching o_data at cycle t+1.
- Fill-to-play: the final word of a frame accepted at cycle t sets full at t+1. The earliest strobe that plays word 0 is at t+1, with output at t+2.
- Back-to-back strobes on every cycle are supported. The bank toggle adds no bubble when the next bank is already full.
- Simultaneous events in one cycle: write completes bank A while read drains bank B. Both take effect; no loss.
- Write and read of the same address never coincide, because bank ownership is exclusive.
- Reset mid-frame: all stored frames and any partial frame are discarded immediately (asynchronous). No pulses are emitted.

## Test plan
Bench runs with FFT_POINT=16 and DATA_W=16.
- Single frame: burst data 0..15, last on word 15, then a strobe every 4 cycles. Required: o_data 0..15 in order, each o_valid exactly 1 cycle after its strobe, then no further o_valid.
- Continuous: 4 frames (base values 0x100, 0x200, 0x300, 0x400), each burst arriving within one frame's playout time, strobes every cycle. Required: 64 contiguous outputs, no gap at the frame boundaries, no overflow or underflow.
- Overflow: 3 bursts back-to-back, no strobes. Required: o_overflow pulses once, on the last word of frame 3. Strobes then replay frames 1 and 2 only, 32 words.
- Frame error: last asserted on word 9. Required: o_frame_err pulses once and nothing plays. A following valid 16-word frame plays correctly.
- Underflow: play 1 frame, then 3 more strobes. Required: 3 o_underflow pulses and no o_valid. Strobes issued before the first frame produce neither.
- Asynchronous reset: drop rst_n while the first of 2 buffered frames is mid-playout. Required: all outputs 0 immediately, and later strobes produce no output or underflow until a new frame arrives.
